// File: rtl/mem_pkg.sv
// Purpose : shared types and constants for the data-memory responder slice.
// Contents: FSM state enum, RISC-V load/store funct3 codes, byte-lane width,
//           and a helper that tells whether a funct3 code is legal for the
//           access direction.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Load codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned BYTE_W = 8;

    // Legal codes: stores accept SB/SH/SW only, loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Purpose : request/response bus between a core (master) and the data-memory
//           responder (slave).
// Signals : req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3 carry a
//           load or store request; rsp_valid/rsp_ready/rsp_rdata/rsp_err carry
//           its single response.
interface dmem_responder_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic [2:0]               req_funct3;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ram.sv
// Purpose : single-port synchronous RAM, MEM_WORDS x DATA_WIDTH, per-byte
//           write enables, registered read. Contents are never reset.
// Ports   : clk (rising edge), en_i (access strobe), be_i (byte write enables,
//           all zero = read), addr_i (word index), wdata_i, rdata_o (registered).
module dmem_ram
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                             clk,
    input  logic                             en_i,
    input  logic [DATA_WIDTH/BYTE_W-1:0]     be_i,
    input  logic [$clog2(MEM_WORDS)-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    output logic [DATA_WIDTH-1:0]            rdata_o
);
    localparam int LANES = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-masked write and read-before-write registered read port
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (be_i[l]) begin
                    mem_q[addr_i][l*BYTE_W +: BYTE_W] <= wdata_i[l*BYTE_W +: BYTE_W];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Purpose : data-memory responder. Accepts one load/store at a time, checks it,
//           steers store lanes into the RAM and sign/zero-extends load data.
// Ports   : clk, rst (async, active high), bus (dmem_responder_if.slave).
// Timing  : accept at edge N -> RAM access at edge N+1 -> response held until
//           rsp_ready, then back to idle.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int MEM_WORDS     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int LANES  = DATA_WIDTH / BYTE_W;
    localparam int RAM_AW = $clog2(MEM_WORDS);
    localparam int IDX_W  = ADDRESS_WIDTH - 2;

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [2:0]               f3_q, f3_d;

    logic [1:0]               lane_s;
    logic [IDX_W-1:0]         idx_s;
    logic                     misalign_s;
    logic                     range_err_s;
    logic                     err_s;
    logic [LANES-1:0]         be_base_s;
    logic [LANES-1:0]         ram_be_s;
    logic                     ram_en_s;
    logic [DATA_WIDTH-1:0]    ram_wdata_s;
    logic [DATA_WIDTH-1:0]    ram_rdata_s;
    logic [DATA_WIDTH-1:0]    shifted_s;
    logic [DATA_WIDTH-1:0]    load_s;

    // State register and captured request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= {ADDRESS_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
        end
    end

    // Next state; request fields are captured only on acceptance in IDLE
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_ACCESS;
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    f3_d    = bus.req_funct3;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign lane_s = addr_q[1:0];
    assign idx_s  = addr_q[ADDRESS_WIDTH-1:2];

    // Alignment check keyed on access size (funct3[1:0]); byte never misaligns
    always_comb begin
        misalign_s = 1'b0;
        case (f3_q[1:0])
            2'b01:   misalign_s = addr_q[0];
            2'b10:   misalign_s = (addr_q[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // No wrap-around: any word index past the array end is rejected
    assign range_err_s = 32'(idx_s) >= 32'(MEM_WORDS);
    assign err_s       = !f3_legal(we_q, f3_q) || misalign_s || range_err_s;

    // Lane mask before shifting to the addressed byte lane
    always_comb begin
        be_base_s = {LANES{1'b0}};
        case (f3_q[1:0])
            2'b00:   be_base_s = {{(LANES-1){1'b0}}, 1'b1};
            2'b01:   be_base_s = {{(LANES-2){1'b0}}, 2'b11};
            default: be_base_s = {LANES{1'b1}};
        endcase
    end

    // Rejected requests never touch the RAM, so an error cannot corrupt memory
    assign ram_en_s    = (state_q == ST_ACCESS) && !err_s;
    assign ram_be_s    = we_q ? (be_base_s << lane_s) : {LANES{1'b0}};
    assign ram_wdata_s = wdata_q << {lane_s, 3'b000};

    dmem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_s),
        .be_i    (ram_be_s),
        .addr_i  (idx_s[RAM_AW-1:0]),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Bring the addressed lane down to bit 0, then sign/zero-extend
    assign shifted_s = ram_rdata_s >> {lane_s, 3'b000};

    // Load extension by funct3
    always_comb begin
        load_s = {DATA_WIDTH{1'b0}};
        case (f3_q)
            F3_LB:   load_s = {{(DATA_WIDTH-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_LH:   load_s = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   load_s = shifted_s;
            F3_LBU:  load_s = {{(DATA_WIDTH-8){1'b0}},  shifted_s[7:0]};
            F3_LHU:  load_s = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
            default: load_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Outputs are decoded from registered state only; the RAM read register
    // holds steady through RESP because the RAM is enabled only in ACCESS.
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = (state_q == ST_RESP) && err_s;
    assign bus.rsp_rdata = ((state_q == ST_RESP) && !we_q && !err_s) ? load_s
                                                                      : {DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(16)) bus_if ();

    dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(16), .MEM_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Byte-addressed reference memory (little-endian)
    logic [7:0]  mb [0:4095];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: expected error flag and load data straight from the rules
    task automatic model(input logic we, input logic [15:0] a, input logic [2:0] f3,
                         output logic [31:0] rd, output logic e);
        int sz;
        int unsigned idx;
        logic [7:0]  b;
        logic [15:0] h;
        e   = 1'b0;
        rd  = 32'h0;
        idx = int'(a) / 4;
        if (we) e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz = int'(f3) % 4;
        if (sz == 1 && (int'(a) % 2) != 0) e = 1'b1;
        if (sz == 2 && (int'(a) % 4) != 0) e = 1'b1;
        if (idx >= 1024) e = 1'b1;
        if (!e && !we) begin
            b = mb[a];
            h = {mb[a+16'd1], mb[a]};
            case (f3)
                3'd0: rd = 32'($signed(b));
                3'd1: rd = 32'($signed(h));
                3'd2: rd = {mb[a+16'd3], mb[a+16'd2], mb[a+16'd1], mb[a]};
                3'd4: rd = {24'h0, b};
                3'd5: rd = {16'h0, h};
                default: rd = 32'h0;
            endcase
        end
    endtask

    task automatic model_store(input logic [15:0] a, input logic [31:0] wd, input logic [2:0] f3);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) mb[a + 16'(i)] = wd[i*8 +: 8];
    endtask

    // Continuous comparison of any presented response against the model
    always @(negedge clk) begin
        if (!rst && exp_active && bus_if.rsp_valid) begin
            chk("cmp_rdata", bus_if.rsp_rdata, exp_rdata);
            chk("cmp_err", {31'h0, bus_if.rsp_err}, {31'h0, exp_err});
        end
    end

    // One full transaction; stall>0 holds rsp_ready low and injects a stray request
    task automatic txn(input logic we, input logic [15:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input int stall,
                       output logic [31:0] rd, output logic er);
        logic [31:0] m_rd;
        logic        m_e;
        int          n;
        model(we, a, f3, m_rd, m_e);
        exp_rdata = m_rd;
        exp_err   = m_e;
        exp_active = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        bus_if.req_funct3 = f3;
        bus_if.req_valid  = 1'b1;
        bus_if.rsp_ready  = (stall == 0);
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        chk("access_no_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
        chk("access_not_ready", {31'h0, bus_if.req_ready}, 32'h0);
        @(posedge clk); #1;
        chk("latency_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
        n = 0;
        while (!bus_if.rsp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        rd = bus_if.rsp_rdata;
        er = bus_if.rsp_err;
        for (int i = 0; i < stall; i++) begin
            if (i == 0) begin
                bus_if.req_we     = 1'b1;
                bus_if.req_addr   = a;
                bus_if.req_wdata  = 32'hBADBAD00;
                bus_if.req_funct3 = 3'd2;
                bus_if.req_valid  = 1'b1;
            end
            @(posedge clk); #1;
            bus_if.req_valid = 1'b0;
            chk("stall_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
            chk("stall_rdata", bus_if.rsp_rdata, rd);
            chk("stall_err", {31'h0, bus_if.rsp_err}, {31'h0, er});
        end
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("back_idle_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
        chk("back_idle_ready", {31'h0, bus_if.req_ready}, 32'h1);
        exp_active = 1'b0;
        if (we && !m_e) model_store(a, wd, f3);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_addr   = 16'h0;
        bus_if.req_wdata  = 32'h0;
        bus_if.req_funct3 = 3'd0;
        bus_if.rsp_ready  = 1'b1;

        @(posedge clk); #1;
        chk("rst_ready", {31'h0, bus_if.req_ready}, 32'h1);
        chk("rst_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
        chk("rst_rdata", bus_if.rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, bus_if.rsp_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic store/load
        txn(1'b1, 16'h0010, 32'hDEADBEEF, 3'd2, 0, rd, er);
        chk("sw_rdata_zero", rd, 32'h0);
        chk("sw_err", {31'h0, er}, 32'h0);
        txn(1'b0, 16'h0010, 32'h0, 3'd2, 0, rd, er);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);
        chk("lw_err", {31'h0, er}, 32'h0);

        // Extension cases
        txn(1'b1, 16'h0020, 32'h80FF7F01, 3'd2, 0, rd, er);
        txn(1'b0, 16'h0023, 32'h0, 3'd0, 0, rd, er);
        chk("lb_23", rd, 32'hFFFFFF80);
        txn(1'b0, 16'h0023, 32'h0, 3'd4, 0, rd, er);
        chk("lbu_23", rd, 32'h00000080);
        txn(1'b0, 16'h0022, 32'h0, 3'd1, 0, rd, er);
        chk("lh_22", rd, 32'hFFFF80FF);
        txn(1'b0, 16'h0020, 32'h0, 3'd5, 0, rd, er);
        chk("lhu_20", rd, 32'h00007F01);
        txn(1'b0, 16'h0021, 32'h0, 3'd4, 0, rd, er);
        chk("lbu_21", rd, 32'h0000007F);

        // Byte-lane store
        txn(1'b1, 16'h0020, 32'h11223344, 3'd2, 0, rd, er);
        txn(1'b1, 16'h0021, 32'h000000AA, 3'd0, 0, rd, er);
        txn(1'b0, 16'h0020, 32'h0, 3'd2, 0, rd, er);
        chk("sb_lanes", rd, 32'h1122AA44);
        txn(1'b1, 16'h0022, 32'h0000BEEF, 3'd1, 0, rd, er);
        txn(1'b0, 16'h0020, 32'h0, 3'd2, 0, rd, er);
        chk("sh_upper", rd, 32'hBEEFAA44);

        // Error cases
        txn(1'b1, 16'h0004, 32'h55667788, 3'd2, 0, rd, er);
        txn(1'b0, 16'h0012, 32'h0, 3'd2, 0, rd, er);
        chk("lw_mis_err", {31'h0, er}, 32'h1);
        chk("lw_mis_rdata", rd, 32'h0);
        txn(1'b1, 16'h0005, 32'h0000FFFF, 3'd1, 0, rd, er);
        chk("sh_mis_err", {31'h0, er}, 32'h1);
        chk("sh_mis_rdata", rd, 32'h0);
        txn(1'b0, 16'h0004, 32'h0, 3'd2, 0, rd, er);
        chk("sh_mis_nowrite", rd, 32'h55667788);
        txn(1'b0, 16'h1000, 32'h0, 3'd2, 0, rd, er);
        chk("lw_range_err", {31'h0, er}, 32'h1);
        chk("lw_range_rdata", rd, 32'h0);
        txn(1'b0, 16'h0FFC, 32'h0, 3'd2, 0, rd, er);
        chk("lw_last_ok", {31'h0, er}, 32'h0);
        txn(1'b0, 16'h0010, 32'h0, 3'd3, 0, rd, er);
        chk("f3_011_err", {31'h0, er}, 32'h1);
        chk("f3_011_rdata", rd, 32'h0);
        txn(1'b1, 16'h0010, 32'h0, 3'd4, 0, rd, er);
        chk("sbu_err", {31'h0, er}, 32'h1);

        // Backpressure with a stray request pulse
        txn(1'b0, 16'h0010, 32'h0, 3'd2, 5, rd, er);
        chk("stall_lw", rd, 32'hDEADBEEF);
        txn(1'b0, 16'h0010, 32'h0, 3'd2, 0, rd, er);
        chk("stall_no_capture", rd, 32'hDEADBEEF);

        // Reset during ACCESS suppresses the store
        txn(1'b1, 16'h0040, 32'hCAFEF00D, 3'd2, 0, rd, er);
        bus_if.req_we     = 1'b1;
        bus_if.req_addr   = 16'h0040;
        bus_if.req_wdata  = 32'h12345678;
        bus_if.req_funct3 = 3'd2;
        bus_if.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_acc_ready", {31'h0, bus_if.req_ready}, 32'h1);
        chk("rst_acc_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
        chk("rst_acc_rdata", bus_if.rsp_rdata, 32'h0);
        chk("rst_acc_err", {31'h0, bus_if.rsp_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 16'h0040, 32'h0, 3'd2, 0, rd, er);
        chk("rst_store_suppressed", rd, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 16, request byte-address width.
REQ-003 Parameter MEM_WORDS, default 1024, storage depth in DATA_WIDTH words.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  core presents a load/store request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDRESS_WIDTH  byte address.
REQ-010 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 req_funct3  input  3  RISC-V access size/sign code.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  core accepts the response.
REQ-014 rsp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  access rejected.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready = 1 only in IDLE, and rsp_valid = 1 only in RESP.
REQ-017 IDLE -> ACCESS on the edge where req_valid && req_ready; all request fields SHALL be captured at that edge.
REQ-018 ACCESS -> RESP unconditionally on the next edge; on that edge, RAM reads SHALL be registered and legal stores SHALL be committed.
REQ-019 RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_valid && rsp_ready; on that edge, RESP -> IDLE.
REQ-020 Latency: acceptance at edge N gives rsp_valid high after edge N+1; minimum spacing is one transaction per 3 cycles; no overlapping requests.
REQ-021 Load codes: 000 LB (sign-extend byte), 001 LH (sign-extend half), 010 LW, 100 LBU (zero-extend byte), 101 LHU (zero-extend half).
REQ-022 Store codes: 000 SB, 001 SH, 010 SW; only the addressed byte lanes SHALL be written, little-endian, lane = req_addr[1:0].
REQ-023 A request SHALL be an error when any of the following holds:
  - illegal code: loads 011/110/111, stores other than 000-010;
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0;
  - addr[ADDRESS_WIDTH-1:2] >= MEM_WORDS.
REQ-024 Erroring requests SHALL write nothing and SHALL respond with rsp_err = 1 and rsp_rdata = 0; they take the same FSM path and latency.
REQ-025 Stores SHALL respond with rsp_err = 0 (if legal) and rsp_rdata = 0.
REQ-026 req_valid asserted outside IDLE SHALL be ignored, with no capture.
REQ-027 Word index SHALL be addr[ADDRESS_WIDTH-1:2] with no wrap-around; out-of-range addresses error per REQ-023.

Reset
REQ-028 While rst = 1, the state SHALL be IDLE and outputs SHALL be req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 Reset in ACCESS SHALL abort the transaction; reset asserted before the ACCESS->RESP edge SHALL suppress the store.
REQ-030 Reset in RESP SHALL drop the response.
REQ-031 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-032 Package mem_pkg SHALL hold the state enum, the funct3 constants (LB..LHU, SB..SW) and the byte-lane width constant.
REQ-033 Storage SHALL be a sub-module dmem_ram: single-port synchronous RAM, MEM_WORDS x DATA_WIDTH, per-byte write enables, registered read.
REQ-034 dmem_responder SHALL contain the FSM, decode/error check, lane steering and load extension.

Verification
REQ-035 SW 0xDEADBEEF @0x0010, then LW @0x0010 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0; rsp_valid high 2 cycles after acceptance.
REQ-036 With word 0x80FF7F01 @0x0020:
  - LB @0x0023 -> 0xFFFFFF80;
  - LBU @0x0023 -> 0x00000080;
  - LH @0x0022 -> 0xFFFF80FF;
  - LHU @0x0020 -> 0x00007F01.
REQ-037 SB 0xAA @0x0021 over 0x11223344, then LW @0x0020 -> 0x1122AA44, confirming other lanes are untouched.
REQ-038 Error cases, each -> rsp_err = 1, rsp_rdata = 0, memory unchanged:
  - LW @0x0012;
  - SH @0x0005;
  - LW @0x1000 (MEM_WORDS = 1024);
  - funct3 = 011 load.
REQ-039 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and data stay stable, and a req_valid pulse during the stall is ignored; rsp_ready = 1 -> IDLE on the next edge.
REQ-040 Assert rst during ACCESS of SW 0x12345678 @0x0040 -> outputs per REQ-028 immediately; a subsequent LW @0x0040 returns the prior contents.
